// File: rtl/rr_encoder_8to3.sv
// rtl/rr_encoder_8to3.sv - registered round-robin 8-to-3 request encoder with hold timeout
// Feeds a 3-to-8 decoder; a forced idle bubble keeps its one-hot from switching directly between requesters.
module rr_encoder_8to3 #(
  parameter int HOLD_W   = 4,
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       release_i,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);

  state_t            state, state_nxt;
  logic [2:0]        ptr, ptr_nxt;
  logic [2:0]        idx_nxt;
  logic [2:0]        sel;
  logic [2:0]        pos;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              timeout_nxt;
  logic              drop_end;
  logic              limit_hit;

  // Scan from the far end back to ptr so the nearest set bit (in rotation order) wins.
  always_comb begin
    sel = 3'd0;
    pos = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      pos = ptr + 3'(k);
      if (req[pos]) sel = pos;
    end
  end

  assign drop_end  = release_i || !req[grant_idx];
  assign limit_hit = (HOLD_MAX != 0) && (hold_cnt == HOLD_LIM);

  always_comb begin
    state_nxt   = state;
    idx_nxt     = grant_idx;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = GRANT;
          idx_nxt   = sel;
          hold_nxt  = HOLD_W'(1);
        end
      end
      GRANT: begin
        if (drop_end || limit_hit) begin
          state_nxt   = IDLE;
          ptr_nxt     = grant_idx + 3'd1;
          // Release or request drop wins over the limit on the same edge.
          timeout_nxt = !drop_end;
        end else if (hold_cnt != {HOLD_W{1'b1}}) begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      hold_cnt  <= '0;
      grant_idx <= 3'd0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
      grant_idx <= idx_nxt;
      timeout   <= timeout_nxt;
    end
  end

  assign grant_valid = (state == GRANT);

endmodule

// File: tb/tb_rr_encoder_8to3.sv
// tb/tb_rr_encoder_8to3.sv - directed self-checking bench for rr_encoder_8to3
// Instance a0 runs with the timeout disabled, instance a3 with HOLD_MAX=3.
module tb_rr_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req0 = 8'h00, req3 = 8'h00;
  logic       rel0 = 1'b0, rel3 = 1'b0;
  logic [2:0] idx0, idx3;
  logic       gv0, gv3, to0, to3;
  int         passed = 0;
  int         total  = 0;

  always #5 clk = ~clk;

  rr_encoder_8to3 #(.HOLD_W(4), .HOLD_MAX(0)) a0 (
    .clk(clk), .rst(rst), .req(req0), .release_i(rel0),
    .grant_idx(idx0), .grant_valid(gv0), .timeout(to0)
  );

  rr_encoder_8to3 #(.HOLD_W(4), .HOLD_MAX(3)) a3 (
    .clk(clk), .rst(rst), .req(req3), .release_i(rel3),
    .grant_idx(idx3), .grant_valid(gv3), .timeout(to3)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_gv0", {7'd0, gv0}, 8'd0);
    chk("rst_idx0", {5'd0, idx0}, 8'd0);
    chk("rst_to0", {7'd0, to0}, 8'd0);
    chk("rst_gv3", {7'd0, gv3}, 8'd0);
    chk("rst_to3", {7'd0, to3}, 8'd0);

    // Release in IDLE has no effect
    rel0 = 1'b1;
    tick();
    chk("idle_rel_gv", {7'd0, gv0}, 8'd0);
    rel0 = 1'b0;

    // Single request held with no timeout
    req0 = 8'h04;
    tick();
    chk("single_gv", {7'd0, gv0}, 8'd1);
    chk("single_idx", {5'd0, idx0}, 8'd2);
    for (int i = 0; i < 20; i++) tick();
    chk("single_hold_gv", {7'd0, gv0}, 8'd1);
    chk("single_hold_idx", {5'd0, idx0}, 8'd2);
    chk("single_hold_to", {7'd0, to0}, 8'd0);
    req0 = 8'h00;
    tick();
    chk("single_drop_gv", {7'd0, gv0}, 8'd0);

    // Fair rotation with one bubble between grants
    do_reset();
    req0 = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("rot%0d_gv", i), {7'd0, gv0}, 8'd1);
      chk($sformatf("rot%0d_idx", i), {5'd0, idx0}, 8'(i % 8));
      rel0 = 1'b1;
      tick();
      chk($sformatf("rot%0d_bubble", i), {7'd0, gv0}, 8'd0);
      rel0 = 1'b0;
    end

    // Pointer skip and wrap
    do_reset();
    req0 = 8'h40;
    tick();
    chk("skip_first_idx", {5'd0, idx0}, 8'd6);
    rel0 = 1'b1;
    req0 = 8'h21;
    tick();
    chk("skip_bubble", {7'd0, gv0}, 8'd0);
    rel0 = 1'b0;
    tick();
    chk("skip_wrap_gv", {7'd0, gv0}, 8'd1);
    chk("skip_wrap_idx", {5'd0, idx0}, 8'd0);
    rel0 = 1'b1;
    tick();
    rel0 = 1'b0;
    tick();
    chk("skip_next_idx", {5'd0, idx0}, 8'd5);
    rel0 = 1'b1;
    req0 = 8'h00;
    tick();
    rel0 = 1'b0;

    // Timeout with HOLD_MAX=3
    do_reset();
    req3 = 8'h08;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("to_hold%0d_gv", i), {7'd0, gv3}, 8'd1);
      chk($sformatf("to_hold%0d_idx", i), {5'd0, idx3}, 8'd3);
      chk($sformatf("to_hold%0d_to", i), {7'd0, to3}, 8'd0);
    end
    tick();
    chk("to_end_gv", {7'd0, gv3}, 8'd0);
    chk("to_pulse", {7'd0, to3}, 8'd1);
    tick();
    chk("to_regrant_gv", {7'd0, gv3}, 8'd1);
    chk("to_regrant_idx", {5'd0, idx3}, 8'd3);
    chk("to_pulse_clear", {7'd0, to3}, 8'd0);

    // Request drop on the same edge as the limit: no timeout
    tick();
    tick();
    chk("coll_pre_gv", {7'd0, gv3}, 8'd1);
    req3 = 8'h00;
    tick();
    chk("coll_gv", {7'd0, gv3}, 8'd0);
    chk("coll_to", {7'd0, to3}, 8'd0);

    // Release coinciding with grant issue is not seen
    do_reset();
    req0 = 8'h01;
    rel0 = 1'b1;
    tick();
    chk("rel_on_grant_gv", {7'd0, gv0}, 8'd1);
    tick();
    chk("rel_after_grant_gv", {7'd0, gv0}, 8'd0);
    rel0 = 1'b0;
    req0 = 8'h00;
    tick();

    // Asynchronous reset mid-grant
    do_reset();
    req0 = 8'h20;
    tick();
    chk("mid_pre_idx", {5'd0, idx0}, 8'd5);
    chk("mid_pre_gv", {7'd0, gv0}, 8'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_gv", {7'd0, gv0}, 8'd0);
    chk("mid_rst_idx", {5'd0, idx0}, 8'd0);
    chk("mid_rst_to", {7'd0, to0}, 8'd0);
    req0 = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_gv", {7'd0, gv0}, 8'd1);
    chk("post_rst_idx", {5'd0, idx0}, 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rr_encoder_8to3.md
# rr_encoder_8to3

Registered round-robin request encoder that turns eight independent request lines into a 3-bit grant index plus valid. It is the stage directly upstream of the 3-to-8 decoder: `grant_idx` drives the decoder's 3-bit select and `grant_valid` qualifies the decoder's one-hot output. Fair rotation, a hold counter with forced timeout, and a mandatory one-cycle bubble between grants ensure the downstream one-hot never switches directly from one requester to another.

## Interface
- `HOLD_W`, default 4: width of the hold counter.
- `HOLD_MAX`, default 15: maximum consecutive cycles `grant_valid` may stay high for one grant. Legal range is 0..2^HOLD_W-1. A value of 0 disables the timeout.

- `clk`  in  1  Single clock. All state updates on the rising edge.
- `rst`  in  1  Reset, asynchronous, active-high.
- `req`  in  8  Request lines. Bit i requests grant index i. Level-sensitive.
- `release_i`  in  1  Holder finished. Sampled only while a grant is active.
- `grant_idx`  out  3  Index of the current grant, registered. Feeds decoder select.
- `grant_valid`  out  1  Grant active, registered.
- `timeout`  out  1  One-cycle pulse when a grant is ended by `HOLD_MAX`.

## Operation
- State machine states: IDLE and GRANT.
  - `grant_valid` is 1 exactly when the state is GRANT.
- Internal registers:
  - `ptr[2:0]`: rotation start point.
  - `hold_cnt[HOLD_W-1:0]`: cycles held in the current grant.
- In IDLE:
  - If `req` is non-zero, select the first set bit scanning ptr, ptr+1, …, ptr+7 (mod 8).
  - On that edge: register `grant_idx` to the selected index, set `hold_cnt` to 1, go to GRANT.
  - If `req` is 0: stay in IDLE. `grant_idx` holds its last value.
- In GRANT, end the grant at the next edge if any of these is true:
  - `release_i` is 1;
  - `req[grant_idx]` is 0;
  - `HOLD_MAX` is non-zero and `hold_cnt` equals `HOLD_MAX`.
- On ending a grant:
  - Go to IDLE and set `ptr` to `grant_idx`+1 (mod 8; 7 wraps to 0).
  - Set `timeout` to 1 for the following cycle only if the timeout condition was the sole cause. Release or request drop takes priority over timeout on the same edge.
- Otherwise, in GRANT: stay, and increment `hold_cnt` (saturating).
- Index arithmetic is 3-bit modulo 8. Scan order depends only on `ptr`; bit position carries no fixed priority.
- Requests arriving during GRANT are ignored until the next IDLE scan.
- `grant_idx` never changes while `grant_valid` is 1.

## Timing
- Reset values: `grant_idx`=0, `grant_valid`=0, `timeout`=0, `ptr`=0, `hold_cnt`=0, state IDLE.
  - Reset takes effect immediately and asynchronously, including mid-grant.
  - After reset deassertion, the first scan starts at index 0.
- Request-to-grant latency: 1 cycle. `req` sampled at edge k gives `grant_valid`=1 after edge k.
- End-of-grant latency: `release_i`, a request drop or a timeout sampled at edge k gives `grant_valid`=0 after edge k.
- Inter-grant bubble: `grant_valid` is low for at least one full cycle between consecutive grants, even with requests pending. Back-to-back grants are therefore 1 bubble cycle apart.
- Maximum hold: with `HOLD_MAX`=M>0 and a holder that never releases, `grant_valid` is high for exactly M cycles. `timeout` is high during the following bubble cycle.
- `release_i` in IDLE has no effect.
- `release_i` on the same edge as the grant is issued is not seen: release is only sampled in GRANT.
- Outputs are purely registered; there is no combinational path from inputs to outputs.

## Test plan
- Single request: after reset, `req`=8'b0000_0100 held, `release_i`=0, `HOLD_MAX`=0 → one cycle after the first edge, `grant_idx`=2 and `grant_valid`=1, and both stay stable indefinitely.
- Fair rotation: `req`=8'hFF constant, `release_i` pulsed on each grant's first GRANT cycle → grant sequence 0,1,2,3,4,5,6,7,0, with `grant_valid` low for exactly one cycle between each grant.
- Pointer skip and wrap: grant 6 then release, then `req`=8'b0010_0001 → next grant is 0 (scan 7, 0), not 5. Then release → next grant is 5.
- Timeout: `HOLD_MAX`=3, `req`=8'h08 held, no release → `grant_valid` high for 3 cycles with `grant_idx`=3, then low with a 1-cycle `timeout` pulse, then regrant 3 after the bubble.
- Request drop versus timeout collision: `HOLD_MAX`=3, and `req[3]` drops on the edge where `hold_cnt`=3 → grant ends and `timeout` stays 0.
- Reset mid-grant: assert `rst` asynchronously between edges while `grant_idx`=5 and `grant_valid`=1 → `grant_valid`, `grant_idx` and `timeout` go to 0 immediately. After release with `req`=8'hFF, the first grant is 0.
